alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Initiator side of the ALU op/operand/flag interface.
- Accepts 32-bit instruction words over a valid/ready handshake and reads operands from an internal 16x32 register file.
- Drives alu_op/alu_a/alu_b for one execute cycle, then captures alu_out and the flags at the next posedge.
- Writes back rd, maintains the status register, and presents each result on a valid/ready output port.

Parameters:
- REG_COUNT, 16, number of 32-bit registers; index width fixed at 4 bits.
- IMM_W, 11, immediate field width; zero-extended to 32 bits.

Ports:
- clk  in  1  system clock; the ALU evaluates on negedge, this block on posedge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  block can accept; high only in IDLE.
- instr  in  32  fields: op[31:24], rd[23:20], ra[19:16], rb[15:12], imm_sel[11], imm[10:0].
- alu_op  out  8  ALU opcode.
- alu_a  out  32  ALU operand a.
- alu_b  out  32  ALU operand b.
- alu_out  in  32  ALU result.
- alu_z, alu_n, alu_c, alu_v, alu_s, alu_h  in  1 each  ALU flags.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  32  written-back value; 0 on error.
- res_rd  out  4  destination index.
- res_err  out  1  illegal instruction; qualified by res_valid.
- status  out  6  {h,s,v,c,n,z}.
- dbg_addr  in  4  debug register index.
- dbg_data  out  32  combinational read of reg[dbg_addr].

Behaviour:
- Reset values: all registers 0, status 0, alu_op 0x00 (ALU ignores it), alu_a/alu_b 0, res_* 0, state IDLE. Reset mid-operation discards any in-flight ALU result.
- State machine has three states: IDLE, EXEC, WB.
- IDLE: instr_ready=1. On an edge with instr_valid:
  - register alu_op=op, alu_a=reg[ra], alu_b = imm_sel ? zero-extended imm : reg[rb];
  - latch rd and a legality bit;
  - go to EXEC.
- EXEC (one cycle): operands held stable; the ALU result settles at the mid-cycle negedge. At the next edge, go to WB and perform write-back:
  - if legal and rd!=0: reg[rd] <= alu_out;
  - if legal and op!=0x01: status <= {alu_h, alu_s, alu_v, alu_c, alu_n, alu_z}. LD (0x01) preserves status;
  - res_valid<=1, res_data<=alu_out (0 if illegal), res_rd<=rd, res_err<=~legal.
- WB: hold all res_* until an edge with res_ready=1, then res_valid<=0 and go to IDLE.
- Latency: accept at edge N, res_valid high from edge N+1. Best-case throughput is one instruction per 3 cycles.
- Legal opcodes are 0x01, 0x03–0x0A.
- Also illegal: SL/SR (0x09/0x0A) with b==0 or b>32.
- Illegal instructions make no register or status write, but still complete the result handshake.
- r0 reads as 0; writes to r0 are discarded, but status still updates.
- Operands are read at the accept edge, so there is no hazard; instructions are strictly serial.
- dbg_data returns the pre-write value during the cycle whose closing edge writes that register.
- alu_op/alu_a/alu_b hold their last values in WB and IDLE until the next accept.

Optional Feature:
- Macro: ALU_CMP_EN.
- Defined: opcode 0x0B (CMP) is legal. It is issued to the ALU as 0x04 (SUB); status updates from the flags; no register write; res_data = difference.
- Undefined: 0x0B is illegal (res_err=1, no writes).

Test Plan:
- After reset, instr ADD r1=r0+imm 5 (0x03100805): res_valid exactly 1 cycle after accept; res_data=5; reg1=5; status z=0.
- reg1=0x7FFFFFFF, ADD r2=r1+imm 1: res_data=0x80000000; status n=1, v=1, c=0.
- SUB r3=r1-r1 sets z=1; then LD r4=r1: status stays z=1 and reg4=reg1.
- op 0x02, and SL with b=0: res_err=1, res_data=0, register file and status unchanged.
- Hold res_ready=0 for 4 cycles: res_* stable, instr_ready=0 throughout. Assert rst in EXEC: all outputs 0, state IDLE, no write to rd.
- Opcode 0x0B with reg1=reg2: with ALU_CMP_EN, z=1 and no write; without it, res_err=1.

Source files
------------

// File: rtl/alu_sequencer.sv
// Sequencer for an external ALU: decodes instructions, reads operands, writes back results and status.
// Optional macro ALU_CMP_EN makes opcode 0x0B (CMP) legal, issuing it to the ALU as SUB.
module alu_sequencer #(
    parameter int unsigned REG_COUNT = 16,
    parameter int unsigned IMM_W     = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [7:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_out,
    input  logic        alu_z,
    input  logic        alu_n,
    input  logic        alu_c,
    input  logic        alu_v,
    input  logic        alu_s,
    input  logic        alu_h,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [3:0]  res_rd,
    output logic        res_err,
    output logic [5:0]  status,
    input  logic [3:0]  dbg_addr,
    output logic [31:0] dbg_data
);
    localparam int unsigned DW  = 32;
    localparam int unsigned RW  = 4;
    localparam int unsigned OPW = 8;
    localparam int unsigned SW  = 6;
    localparam logic [OPW-1:0] OP_LD  = 8'h01;
    localparam logic [OPW-1:0] OP_SUB = 8'h04;
    localparam logic [OPW-1:0] OP_SL  = 8'h09;
    localparam logic [OPW-1:0] OP_SR  = 8'h0A;
    localparam logic [OPW-1:0] OP_CMP = 8'h0B;
`ifdef ALU_CMP_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2} state_t;

    state_t         state_q, state_d;
    logic [DW-1:0]  regs [REG_COUNT];
    logic [RW-1:0]  rd_q, rd_d;
    logic           legal_q, legal_d;
    logic           we_q, we_d;
    logic           se_q, se_d;
    logic           reg_we;
    logic [OPW-1:0] alu_op_d;
    logic [DW-1:0]  alu_a_d, alu_b_d;
    logic           res_valid_d, res_err_d;
    logic [DW-1:0]  res_data_d;
    logic [RW-1:0]  res_rd_d;
    logic [SW-1:0]  status_d;

    logic [OPW-1:0] f_op;
    logic [RW-1:0]  f_rd, f_ra, f_rb;
    logic           f_sel;
    logic [DW-1:0]  f_imm;
    logic [DW-1:0]  opnd_a, opnd_b;
    logic           is_cmp, op_known, shift_bad, legal_c;

    assign f_op  = instr[31:24];
    assign f_rd  = instr[23:20];
    assign f_ra  = instr[19:16];
    assign f_rb  = instr[15:12];
    assign f_sel = instr[11];
    assign f_imm = DW'(instr[IMM_W-1:0]);

    // r0 is never written, so it always reads back as zero
    assign dbg_data = regs[dbg_addr];

    // Operand fetch and legality of the offered instruction
    always_comb begin
        opnd_a   = regs[f_ra];
        opnd_b   = f_sel ? f_imm : regs[f_rb];
        is_cmp   = CMP_EN && (f_op == OP_CMP);
        case (f_op)
            8'h01, 8'h03, 8'h04, 8'h05, 8'h06,
            8'h07, 8'h08, 8'h09, 8'h0A: op_known = 1'b1;
            default:                    op_known = is_cmp;
        endcase
        shift_bad = ((f_op == OP_SL) || (f_op == OP_SR)) &&
                    ((opnd_b == '0) || (opnd_b > DW'(32)));
        legal_c   = op_known && !shift_bad;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        legal_d     = legal_q;
        we_d        = we_q;
        se_d        = se_q;
        reg_we      = 1'b0;
        alu_op_d    = alu_op;
        alu_a_d     = alu_a;
        alu_b_d     = alu_b;
        res_valid_d = res_valid;
        res_data_d  = res_data;
        res_rd_d    = res_rd;
        res_err_d   = res_err;
        status_d    = status;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    alu_op_d = is_cmp ? OP_SUB : f_op;
                    alu_a_d  = opnd_a;
                    alu_b_d  = opnd_b;
                    rd_d     = f_rd;
                    legal_d  = legal_c;
                    we_d     = legal_c && (f_rd != '0) && !is_cmp;
                    se_d     = legal_c && (f_op != OP_LD);
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                reg_we      = we_q;
                if (se_q) status_d = {alu_h, alu_s, alu_v, alu_c, alu_n, alu_z};
                res_valid_d = 1'b1;
                res_data_d  = legal_q ? alu_out : '0;
                res_rd_d    = rd_q;
                res_err_d   = !legal_q;
                state_d     = WB;
            end
            WB: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            instr_ready <= 1'b1;
            rd_q        <= '0;
            legal_q     <= 1'b0;
            we_q        <= 1'b0;
            se_q        <= 1'b0;
            alu_op      <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_rd      <= '0;
            res_err     <= 1'b0;
            status      <= '0;
        end else begin
            state_q     <= state_d;
            instr_ready <= (state_d == IDLE);
            rd_q        <= rd_d;
            legal_q     <= legal_d;
            we_q        <= we_d;
            se_q        <= se_d;
            alu_op      <= alu_op_d;
            alu_a       <= alu_a_d;
            alu_b       <= alu_b_d;
            res_valid   <= res_valid_d;
            res_data    <= res_data_d;
            res_rd      <= res_rd_d;
            res_err     <= res_err_d;
            status      <= status_d;
        end
    end

    // Register file; write-back lands on the edge that closes EXEC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(REG_COUNT); i++) regs[i] <= '0;
        end else if (reg_we) begin
            regs[rd_q] <= alu_out;
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: bench-side ALU, instruction-level reference model, per-cycle compare.
module tb_alu_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic [7:0]  alu_op;
    logic [31:0] alu_a, alu_b;
    logic [31:0] alu_out = '0;
    logic        alu_z = 1'b0, alu_n = 1'b0, alu_c = 1'b0, alu_v = 1'b0, alu_s = 1'b0, alu_h = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic [3:0]  res_rd;
    logic        res_err;
    logic [5:0]  status;
    logic [3:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

`ifdef ALU_CMP_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    bit started = 1'b0;

    alu_sequencer dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
        .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v), .alu_s(alu_s), .alu_h(alu_h),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_rd(res_rd),
        .res_err(res_err), .status(status), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Returns {h,s,v,c,n,z,result}
    function automatic logic [37:0] alu_fn(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] r;
        logic c, v, h, n, z;
        c = 1'b0; v = 1'b0; h = 1'b0; r = '0;
        case (op)
            8'h01: r = a;
            8'h03: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[31:0];
                c = w[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
                h = ({1'b0, a[3:0]} + {1'b0, b[3:0]}) > 5'd15;
            end
            8'h04: begin
                r = a - b;
                c = a < b;
                v = (a[31] != b[31]) && (r[31] != a[31]);
                h = a[3:0] < b[3:0];
            end
            8'h05: r = a & b;
            8'h06: r = a | b;
            8'h07: r = a ^ b;
            8'h08: r = ~a;
            8'h09: r = a << b;
            8'h0A: r = a >> b;
            default: r = '0;
        endcase
        n = r[31];
        z = (r == '0);
        return {h, n ^ v, v, c, n, z, r};
    endfunction

    function automatic logic [31:0] enc(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic sel, input logic [10:0] imm);
        return {op, rd, ra, rb, sel, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ALU evaluates on the falling edge
    always @(negedge clk) begin : alu_model
        logic [37:0] t;
        t = alu_fn(alu_op, alu_a, alu_b);
        alu_out = t[31:0];
        {alu_h, alu_s, alu_v, alu_c, alu_n, alu_z} = t[37:32];
    end

    // Reference model: one pending instruction, its effects applied one edge after accept
    logic [31:0] m_regs [16];
    logic [5:0]  m_status = '0;
    logic [7:0]  m_op = '0;
    logic [31:0] m_a = '0, m_b = '0;
    bit          pending = 1'b0, since = 1'b0;
    logic [31:0] e_data = '0;
    logic [3:0]  e_rd = '0;
    logic        e_err = 1'b0, e_we = 1'b0, e_se = 1'b0;
    logic [5:0]  e_flags = '0;

    initial begin : model
        logic [7:0]  op;
        logic [31:0] a, b;
        logic [37:0] t;
        logic        legal, cmp;
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                pending = 1'b0; since = 1'b0;
                for (int i = 0; i < 16; i++) m_regs[i] = '0;
                m_status = '0; m_op = '0; m_a = '0; m_b = '0;
            end else if (pending) begin
                if (!since) begin
                    since = 1'b1;
                    if (e_we) m_regs[e_rd] = e_data;
                    if (e_se) m_status = e_flags;
                end else if (res_ready) begin
                    pending = 1'b0;
                end
            end else if (instr_valid) begin
                op  = instr[31:24];
                a   = m_regs[instr[19:16]];
                b   = instr[11] ? {21'd0, instr[10:0]} : m_regs[instr[15:12]];
                cmp = CMP_EN && (op == 8'h0B);
                legal = (op == 8'h01) || (op >= 8'h03 && op <= 8'h0A) || cmp;
                if ((op == 8'h09 || op == 8'h0A) && (b == 0 || b > 32)) legal = 1'b0;
                m_op = cmp ? 8'h04 : op;
                m_a  = a;
                m_b  = b;
                t    = alu_fn(m_op, a, b);
                e_data  = legal ? t[31:0] : 32'd0;
                e_err   = !legal;
                e_rd    = instr[23:20];
                e_we    = legal && (instr[23:20] != 4'd0) && !cmp;
                e_se    = legal && (op != 8'h01);
                e_flags = t[37:32];
                pending = 1'b1;
                since   = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin : compare
        forever begin
            @(negedge clk);
            if (started) begin
                chk("instr_ready", 32'(instr_ready), 32'(!pending));
                chk("res_valid", 32'(res_valid), 32'(pending && since));
                if (pending && since) begin
                    chk("res_data", res_data, e_data);
                    chk("res_rd", 32'(res_rd), 32'(e_rd));
                    chk("res_err", 32'(res_err), 32'(e_err));
                end
                chk("status", 32'(status), 32'(m_status));
                chk("alu_op", 32'(alu_op), 32'(m_op));
                chk("alu_a", alu_a, m_a);
                chk("alu_b", alu_b, m_b);
                chk("dbg_data", dbg_data, m_regs[dbg_addr]);
            end
        end
    end

    task automatic align();
        @(posedge clk); #1;
    endtask

    task automatic peek(input logic [3:0] a, output logic [31:0] v);
        dbg_addr = a;
        #1;
        v = dbg_data;
    endtask

    // Issue one instruction from IDLE, hold the result for 'stall' extra cycles, then accept it
    task automatic issue(input logic [31:0] w, input int stall,
                         output logic [31:0] d, output logic e, output logic [5:0] st);
        int n;
        instr = w; instr_valid = 1'b1; dbg_addr = 4'($urandom_range(0, 15));
        @(posedge clk); #1;
        instr_valid = 1'b0; instr = $urandom; dbg_addr = 4'($urandom_range(0, 15));
        n = 0;
        while (n < 6) begin
            @(negedge clk);
            if (res_valid) break;
            @(posedge clk); #1;
            dbg_addr = 4'($urandom_range(0, 15));
            n++;
        end
        chk("latency", 32'(n), 32'd1);
        d = res_data; e = res_err; st = status;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            dbg_addr = 4'($urandom_range(0, 15));
            @(negedge clk);
            chk("stall_valid", 32'(res_valid), 32'd1);
            chk("stall_ready", 32'(instr_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: run still active at t=%0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic [31:0] d, pv, w;
        logic        e;
        logic [5:0]  st;
        logic [7:0]  op;
        logic [10:0] imm;
        int          sel;
        #3 rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        started = 1'b1;
        chk("rst_instr_ready", 32'(instr_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_status", 32'(status), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        peek(4'd1, pv); chk("rst_r1", pv, 32'd0);
        align();

        issue(32'h03100805, 0, d, e, st);
        chk("add5_data", d, 32'd5); chk("add5_err", 32'(e), 32'd0); chk("add5_status", 32'(st), 32'd0);
        peek(4'd1, pv); chk("add5_r1", pv, 32'd5); align();

        issue(enc(8'h03, 4'd5, 4'd0, 4'd0, 1'b1, 11'd1), 0, d, e, st);
        issue(enc(8'h09, 4'd6, 4'd5, 4'd0, 1'b1, 11'd31), 0, d, e, st);
        chk("sl31_data", d, 32'h8000_0000);
        issue(enc(8'h04, 4'd1, 4'd6, 4'd5, 1'b0, 11'd0), 0, d, e, st);
        chk("max_data", d, 32'h7FFF_FFFF);

        issue(enc(8'h03, 4'd2, 4'd1, 4'd0, 1'b1, 11'd1), 4, d, e, st);
        chk("ovf_data", d, 32'h8000_0000); chk("ovf_status", 32'(st), 32'h2A);

        issue(enc(8'h04, 4'd3, 4'd1, 4'd1, 1'b0, 11'd0), 0, d, e, st);
        chk("sub0_data", d, 32'd0); chk("sub0_status", 32'(st), 32'h01);
        issue(enc(8'h01, 4'd4, 4'd1, 4'd0, 1'b0, 11'd0), 0, d, e, st);
        chk("ld_data", d, 32'h7FFF_FFFF); chk("ld_status", 32'(st), 32'h01);
        peek(4'd4, pv); chk("ld_r4", pv, 32'h7FFF_FFFF); align();

        issue(enc(8'h02, 4'd9, 4'd1, 4'd0, 1'b1, 11'd3), 0, d, e, st);
        chk("op02_err", 32'(e), 32'd1); chk("op02_data", d, 32'd0); chk("op02_status", 32'(st), 32'h01);
        issue(enc(8'h09, 4'd7, 4'd1, 4'd0, 1'b1, 11'd0), 0, d, e, st);
        chk("sl0_err", 32'(e), 32'd1); chk("sl0_data", d, 32'd0); chk("sl0_status", 32'(st), 32'h01);
        peek(4'd7, pv); chk("sl0_r7", pv, 32'd0); peek(4'd9, pv); chk("op02_r9", pv, 32'd0); align();
        issue(enc(8'h09, 4'd10, 4'd1, 4'd0, 1'b1, 11'd32), 0, d, e, st);
        chk("sl32_err", 32'(e), 32'd0); chk("sl32_data", d, 32'd0);
        issue(enc(8'h0A, 4'd11, 4'd1, 4'd0, 1'b1, 11'd33), 0, d, e, st);
        chk("sr33_err", 32'(e), 32'd1);
        issue(enc(8'h03, 4'd0, 4'd1, 4'd0, 1'b1, 11'd1), 0, d, e, st);
        chk("r0w_data", d, 32'h8000_0000); chk("r0w_status", 32'(st), 32'h2A);
        peek(4'd0, pv); chk("r0w_r0", pv, 32'd0); align();

        instr = enc(8'h03, 4'd8, 4'd0, 4'd0, 1'b1, 11'd7); instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rex_res_valid", 32'(res_valid), 32'd0); chk("rex_res_data", res_data, 32'd0);
        chk("rex_res_err", 32'(res_err), 32'd0); chk("rex_res_rd", 32'(res_rd), 32'd0);
        chk("rex_status", 32'(status), 32'd0); chk("rex_alu_op", 32'(alu_op), 32'd0);
        chk("rex_alu_a", alu_a, 32'd0); chk("rex_alu_b", alu_b, 32'd0);
        chk("rex_instr_ready", 32'(instr_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        peek(4'd8, pv); chk("rex_r8", pv, 32'd0); align();

        issue(enc(8'h03, 4'd1, 4'd0, 4'd0, 1'b1, 11'd9), 0, d, e, st);
        issue(enc(8'h03, 4'd2, 4'd0, 4'd0, 1'b1, 11'd9), 0, d, e, st);
        issue(enc(8'h03, 4'd3, 4'd0, 4'd0, 1'b1, 11'h55), 0, d, e, st);
        issue(enc(8'h0B, 4'd3, 4'd1, 4'd2, 1'b0, 11'd0), 1, d, e, st);
`ifdef ALU_CMP_EN
        chk("cmp_err", 32'(e), 32'd0); chk("cmp_data", d, 32'd0); chk("cmp_status", 32'(st), 32'h01);
`else
        chk("cmp_err", 32'(e), 32'd1); chk("cmp_data", d, 32'd0); chk("cmp_status", 32'(st), 32'h00);
`endif
        peek(4'd3, pv); chk("cmp_r3", pv, 32'h55); align();

        for (int k = 0; k < 300; k++) begin
            sel = int'($urandom_range(0, 15));
            op  = (sel < 13) ? 8'(sel) : ((sel == 13) ? 8'h09 : 8'h0A);
            imm = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 40)) : 11'($urandom);
            w   = {op, 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), imm};
            issue(w, int'($urandom_range(0, 3)), d, e, st);
            if ($urandom_range(0, 3) == 0) align();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
